mul_operand_feeder: RTL and testbench



---
 rtl/mul_operand_feeder.sv | 162 ++++++++++++++++
 tb/tb_mul_operand_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mul_operand_feeder
// Description : Upstream sequencer for a 16-bit repeated-addition multiplier.
//               Accepts an (A, B) operand pair over valid/ready, pulses the
//               multiplier start, drives A then B on the shared data bus,
//               waits for a rising edge of done and holds the product under
//               a result valid/ready handshake.
//               Optional macro MUL_FEED_TIMEOUT_EN adds a WAIT watchdog
//               that aborts with res_err=1 and res_data=16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_operand_feeder #(
    parameter int unsigned TIMEOUT_CYCLES = 70000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mul_start,
    output logic [15:0] mul_data_in,
    input  logic        mul_done,
    input  logic [15:0] mul_data_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        done_prev_q;
    logic [15:0] res_data_q;
    logic        w_done_rise;
    logic        w_accept;
    logic        w_timeout;

    assign w_accept    = (state_q == S_IDLE) && in_valid;
    assign w_done_rise = mul_done && !done_prev_q;

`ifdef MUL_FEED_TIMEOUT_EN
    logic [16:0] wait_cnt_q;
    logic        res_err_q;

    assign w_timeout = (state_q == S_WAIT) && !w_done_rise &&
                       (wait_cnt_q == 17'(TIMEOUT_CYCLES));

    // Watchdog: zeroed on the way into WAIT, counts every WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_LOAD_B) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 17'd1;
        end
    end

    // Error flag follows whichever event ended the WAIT state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if (state_q == S_WAIT && w_done_rise) begin
            res_err_q <= 1'b0;
        end else if (w_timeout) begin
            res_err_q <= 1'b1;
        end
    end

    assign res_err = res_err_q;
`else
    assign w_timeout = 1'b0;
    // Without the watchdog an abort can never happen; the parameter term is
    // constant-true and only keeps the otherwise idle parameter referenced.
    assign res_err   = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_START;
            S_START:  state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_WAIT;
            S_WAIT:   if (w_done_rise || w_timeout) state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand capture at acceptance; later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (w_accept) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // Previous-cycle done, so a level left high from an earlier run is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_prev_q <= 1'b0;
        end else begin
            done_prev_q <= mul_done;
        end
    end

    // Result register: product on a done edge, all-ones on a watchdog abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
        end else if (state_q == S_WAIT && w_done_rise) begin
            res_data_q <= mul_data_out;
        end else if (w_timeout) begin
            res_data_q <= 16'hFFFF;
        end
    end

    // Bus mux decoded from registered state and operands only
    always_comb begin
        mul_data_in = 16'd0;
        case (state_q)
            S_LOAD_A:         mul_data_in = a_q;
            S_LOAD_B, S_WAIT: mul_data_in = b_q;
            default:          mul_data_in = 16'd0;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mul_start = (state_q == S_START);
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_operand_feeder
// Description : Self-checking bench for mul_operand_feeder with a result
//               scoreboard and a bus-sampling multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_operand_feeder;

`ifdef MUL_FEED_TIMEOUT_EN
    localparam int unsigned C_TIMEOUT = 20;
`else
    localparam int unsigned C_TIMEOUT = 70000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        mul_start;
    logic [15:0] mul_data_in;
    logic        mul_done = 1'b0;
    logic [15:0] mul_data_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard entries are {err, data}
    logic [16:0] exp_q[$];

    mul_operand_feeder #(.TIMEOUT_CYCLES(C_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_data_in (mul_data_in),
        .mul_done    (mul_done),
        .mul_data_out(mul_data_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = {16'd0, a} * {16'd0, b};
        return {1'b0, full[15:0]};
    endfunction

    // Drives one pair through acceptance, samples the operands off the bus
    // like the multiplier would, waits lat cycles in WAIT and then raises
    // done for one cycle. Returns in the cycle after done was sampled.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int lat);
        logic [15:0] ma, mb;
        logic [16:0] p;
        in_a = a; in_b = b; in_valid = 1'b1;
        exp_q.push_back(model_prod(a, b));
        tick();                        // START
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
        tick(); ma = mul_data_in;      // LOAD_A
        tick(); mb = mul_data_in;      // LOAD_B
        tick();                        // WAIT
        repeat (lat) tick();
        p = model_prod(ma, mb);
        mul_data_out = p[15:0]; mul_done = 1'b1;
        tick();
        mul_done = 1'b0; mul_data_out = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_chk++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %b expected 0", mul_start); else n_pass++;
        n_chk++; if (mul_data_in !== 16'h0) $display("FAIL rst_bus: got %h expected 0000", mul_data_in); else n_pass++;
        n_chk++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b expected 0", res_valid); else n_pass++;
        n_chk++; if (res_data !== 16'h0) $display("FAIL rst_res_data: got %h expected 0000", res_data); else n_pass++;
        n_chk++; if (res_err !== 1'b0) $display("FAIL rst_res_err: got %b expected 0", res_err); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [16:0] e;
        in_a = 16'd7; in_b = 16'd5; in_valid = 1'b1;      // cycle T
        exp_q.push_back(model_prod(16'd7, 16'd5));
        tick();                                           // T+1
        in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF;
        n_chk++; if (mul_start !== 1'b1) $display("FAIL basic_start_t1: got %b expected 1", mul_start); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL basic_ready_t1: got %b expected 0", in_ready); else n_pass++;
        tick();                                           // T+2
        n_chk++; if (mul_start !== 1'b0) $display("FAIL basic_start_t2: got %b expected 0", mul_start); else n_pass++;
        n_chk++; if (mul_data_in !== 16'd7) $display("FAIL basic_bus_a: got %h expected 0007", mul_data_in); else n_pass++;
        tick();                                           // T+3
        n_chk++; if (mul_data_in !== 16'd5) $display("FAIL basic_bus_b: got %h expected 0005", mul_data_in); else n_pass++;
        tick();                                           // T+4
        n_chk++; if (mul_data_in !== 16'd5) $display("FAIL basic_bus_hold: got %h expected 0005", mul_data_in); else n_pass++;
        n_chk++; if (mul_start !== 1'b0 || res_valid !== 1'b0) $display("FAIL basic_wait: got start=%b valid=%b expected 0 0", mul_start, res_valid); else n_pass++;
        mul_data_out = 16'd35; mul_done = 1'b1;           // cycle D
        tick();                                           // D+1
        mul_done = 1'b0; mul_data_out = 16'h0;
        n_chk++; if (res_valid !== 1'b1) $display("FAIL basic_res_valid: got %b expected 1", res_valid); else n_pass++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1_FFFF;
        n_chk++; if ({res_err, res_data} !== e) $display("FAIL basic_result: got %h expected %h", {res_err, res_data}, e); else n_pass++;
        res_ready = 1'b1;                                 // cycle R
        n_chk++; if (in_ready !== 1'b0) $display("FAIL basic_no_bypass: got %b expected 0", in_ready); else n_pass++;
        tick();                                           // R+1
        res_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL basic_release: got ready=%b valid=%b expected 1 0", in_ready, res_valid); else n_pass++;
    endtask

    task automatic test_overflow_hold();
        logic [16:0] e;
        run_txn(16'd300, 16'd300, 3);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1_FFFF;
        n_chk++; if (e !== 17'h0_5F90) $display("FAIL ovf_model: got %h expected 05f90", e); else n_pass++;
        n_chk++; if (res_valid !== 1'b1 || {res_err, res_data} !== e) $display("FAIL ovf_result: got valid=%b %h expected 1 %h", res_valid, {res_err, res_data}, e); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if (res_valid !== 1'b1 || res_data !== e[15:0] || in_ready !== 1'b0)
                $display("FAIL ovf_hold[%0d]: got valid=%b data=%h ready=%b expected 1 %h 0", i, res_valid, res_data, in_ready, e[15:0]);
            else n_pass++;
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL ovf_release: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_done_held();
        logic [16:0] e;
        mul_done = 1'b1; mul_data_out = 16'h1111;         // left high by a previous run
        tick();
        in_a = 16'd3; in_b = 16'd4; in_valid = 1'b1;
        exp_q.push_back(model_prod(16'd3, 16'd4));
        tick(); in_valid = 1'b0;
        repeat (3) tick();                                // now in WAIT
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (res_valid !== 1'b0) $display("FAIL held_no_capture[%0d]: got %b expected 0", i, res_valid); else n_pass++;
            tick();
        end
        mul_done = 1'b0; tick(); tick();
        n_chk++; if (res_valid !== 1'b0) $display("FAIL held_fall: got %b expected 0", res_valid); else n_pass++;
        mul_data_out = 16'd12; mul_done = 1'b1;
        tick();
        mul_done = 1'b0; mul_data_out = 16'h0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1_FFFF;
        n_chk++; if (res_valid !== 1'b1 || {res_err, res_data} !== e) $display("FAIL held_result: got valid=%b %h expected 1 %h", res_valid, {res_err, res_data}, e); else n_pass++;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_a = 16'd9; in_b = 16'd9; in_valid = 1'b1;
        exp_q.push_back(model_prod(16'd9, 16'd9));
        tick(); in_valid = 1'b0;
        repeat (4) tick();                                // in WAIT
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1 || mul_data_in !== 16'h0) $display("FAIL mid_async: got busy=%b ready=%b bus=%h expected 0 1 0000", busy, in_ready, mul_data_in); else n_pass++;
        tick(); rst_n = 1'b1; tick();
        mul_data_out = 16'd81; mul_done = 1'b1;
        tick(); mul_done = 1'b0; mul_data_out = 16'h0;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (res_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_no_capture[%0d]: got valid=%b ready=%b expected 0 1", i, res_valid, in_ready); else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av[5];
        logic [15:0] bv[5];
        logic [16:0] e;
        av = '{16'd1234, 16'hFFFF, 16'd2, 16'd0, 16'd0};
        bv = '{16'd0,    16'hFFFF, 16'd3, 16'd0, 16'd0};
        av[3] = 16'($urandom); bv[3] = 16'($urandom_range(0, 40));
        av[4] = 16'($urandom); bv[4] = 16'($urandom_range(0, 40));
        for (int i = 0; i < 5; i++) begin
            run_txn(av[i], bv[i], int'($urandom_range(0, 6)));
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1_FFFF;
            n_chk++;
            if (res_valid !== 1'b1 || {res_err, res_data} !== e)
                $display("FAIL b2b_result[%0d]: got valid=%b %h expected 1 %h", i, res_valid, {res_err, res_data}, e);
            else n_pass++;
            res_ready = 1'b1; tick(); res_ready = 1'b0;
            n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready); else n_pass++;
        end
    endtask

`ifdef MUL_FEED_TIMEOUT_EN
    task automatic test_timeout();
        logic [16:0] e;
        in_a = 16'd10; in_b = 16'd10; in_valid = 1'b1;
        exp_q.push_back(17'h1_FFFF);
        tick(); in_valid = 1'b0;
        repeat (3) tick();                                // WAIT entry cycle W
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_chk++; if (res_valid !== 1'b0) $display("FAIL to_early[%0d]: got %b expected 0", k, res_valid); else n_pass++;
        end
        tick();                                           // W+21
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0_0000;
        n_chk++; if (res_valid !== 1'b1 || {res_err, res_data} !== e) $display("FAIL to_result: got valid=%b %h expected 1 %h", res_valid, {res_err, res_data}, e); else n_pass++;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL to_release: got %b expected 1", in_ready); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow_hold();
        test_done_held();
        test_reset_mid();
        test_back_to_back();
`ifdef MUL_FEED_TIMEOUT_EN
        test_timeout();
`endif
        n_chk++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
